// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Single-outstanding request/acknowledge instruction-memory port.
interface fetch_if;

  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem fetch, stall/redirect handling for IF/ID.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  fetch_if.master     imem,
  output logic [31:0] Inst,
  output logic [31:0] PC_Plus4,
  output logic        flush
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  pc_inc_s;
  logic [31:0]  redir_pc_s;
  logic [31:0]  inst_s;
  logic         req_s;

  assign pc_inc_s   = pc_q + 32'd4;
  assign redir_pc_s = align_pc(RedirectPC);

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      hold_q     <= NOP_INST;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      hold_q     <= hold_d;
    end
  end

  // Next-state logic; Redirect overrides stall and ack handling.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    inst_s  = NOP_INST;
    req_s   = 1'b0;
    case (state_q)
      FETCH: begin
        req_s = 1'b1;
        if (Redirect) begin
          pc_d    = redir_pc_s;
          hold_d  = NOP_INST;
          state_d = imem.ack ? FETCH : DROP;
        end else if (imem.ack) begin
          inst_s = imem.rdata;
          if (PCWrite) begin
            pc_d = pc_inc_s;
          end else begin
            hold_d  = imem.rdata;
            state_d = HOLD;
          end
        end else begin
          inst_s = NOP_INST;
        end
      end
      HOLD: begin
        inst_s = hold_q;
        if (Redirect) begin
          pc_d    = redir_pc_s;
          hold_d  = NOP_INST;
          state_d = FETCH;
        end else if (PCWrite) begin
          pc_d    = pc_inc_s;
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        // Stale request must complete; its data is never presented.
        req_s = 1'b1;
        if (Redirect) begin
          pc_d = redir_pc_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem.ack) begin
          state_d = FETCH;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = FETCH;
        pc_d    = pc_q;
        hold_d  = NOP_INST;
      end
    endcase
    // The address only moves when a fresh request starts in FETCH.
    if (state_d == FETCH) begin
      req_addr_d = pc_d;
    end else begin
      req_addr_d = req_addr_q;
    end
  end

  assign imem.req  = req_s & ~reset;
  assign imem.addr = req_addr_q;
  assign Inst      = reset ? NOP_INST : inst_s;
  assign PC_Plus4  = pc_inc_s;
  assign flush     = Redirect & ~reset;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a variable-latency instruction memory model.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct {
    int          lat;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] plus4;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] plus4;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        PCWrite;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] Inst;
  logic [31:0] PC_Plus4;
  logic        flush;

  int   mem_lat;
  logic mem_hold;
  int   cnt = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[8];

  fetch_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clock      (clock),
    .reset      (reset),
    .PCWrite    (PCWrite),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .imem       (bus.master),
    .Inst       (Inst),
    .PC_Plus4   (PC_Plus4),
    .flush      (flush)
  );

  always #5 clock = ~clock;

  // Memory: acks after mem_lat wait cycles, data = addr ^ KEY.
  assign bus.ack   = bus.req && !mem_hold && (cnt >= mem_lat);
  assign bus.rdata = bus.addr ^ KEY;

  always @(posedge clock) begin
    if (!bus.req || bus.ack) cnt <= 0;
    else                     cnt <= cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_empty got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk("sb_inst", Inst, e.inst);
      chk("sb_plus4", PC_Plus4, e.plus4);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b1; PCWrite = 1'b1; Redirect = 1'b0; RedirectPC = 32'd0;
    mem_lat = 0; mem_hold = 1'b0;

    a = 32'h0000_0100;
    for (int i = 0; i < 8; i++) begin
      tbl[i].addr  = a;
      tbl[i].inst  = a ^ KEY;
      tbl[i].plus4 = a + 32'd4;
      a = a + 32'd4;
    end
    tbl[0].lat = 0; tbl[1].lat = 0; tbl[2].lat = 0; tbl[3].lat = 2;
    tbl[4].lat = 1; tbl[5].lat = 3; tbl[6].lat = 0; tbl[7].lat = 2;

    // Reset values.
    #2;
    Redirect = 1'b1;
    #1;
    chk("rst_inst", Inst, NOP);
    chk("rst_plus4", PC_Plus4, 32'h0000_0104);
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    Redirect = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Table-driven stream with mixed memory latency.
    for (int r = 0; r < 8; r++) begin
      sb.push_back('{inst: tbl[r].inst, plus4: tbl[r].plus4});
      mem_lat = tbl[r].lat;
      for (int c = 0; c <= tbl[r].lat; c++) begin
        #1;
        chk("str_req", {31'd0, bus.req}, 32'd1);
        chk("str_addr", bus.addr, tbl[r].addr);
        if (c < tbl[r].lat) chk("str_bubble", Inst, NOP);
        else                sb_pop();
        cyc();
      end
    end

    // Redirect with ack and stall: data dropped, target fetched, then HOLD.
    mem_lat = 0;
    Redirect = 1'b1; RedirectPC = 32'h0000_0200; PCWrite = 1'b0;
    #1;
    chk("rda_flush", {31'd0, flush}, 32'd1);
    chk("rda_addr", bus.addr, 32'h0000_0120);
    cyc();
    Redirect = 1'b0;
    #1;
    chk("rda_tgt_req", {31'd0, bus.req}, 32'd1);
    chk("rda_tgt_addr", bus.addr, 32'h0000_0200);
    chk("rda_flush0", {31'd0, flush}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      #1;
      chk("hold_req", {31'd0, bus.req}, 32'd0);
      chk("hold_inst", Inst, 32'hA5A5_0200);
    end
    cyc();
    PCWrite = 1'b1;
    #1;
    chk("hold_consume", Inst, 32'hA5A5_0200);
    chk("hold_plus4", PC_Plus4, 32'h0000_0204);
    cyc();
    #1;
    chk("post_hold_addr", bus.addr, 32'h0000_0204);
    sb.push_back('{inst: 32'hA5A5_0204, plus4: 32'h0000_0208});
    sb_pop();
    cyc();

    // Redirect while the 0x300 request is pending on a 2-cycle memory.
    Redirect = 1'b1; RedirectPC = 32'h0000_0300;
    #1;
    chk("r300_flush", {31'd0, flush}, 32'd1);
    cyc();
    mem_lat = 1;
    RedirectPC = 32'h0000_0403;
    #1;
    chk("drop_flush", {31'd0, flush}, 32'd1);
    chk("drop_addr0", bus.addr, 32'h0000_0300);
    chk("drop_inst0", Inst, NOP);
    cyc();
    Redirect = 1'b0;
    #1;
    chk("drop_addr1", bus.addr, 32'h0000_0300);
    chk("drop_req1", {31'd0, bus.req}, 32'd1);
    chk("drop_stale", Inst, NOP);
    chk("drop_flush1", {31'd0, flush}, 32'd0);
    cyc();
    #1;
    chk("tgt_addr0", bus.addr, 32'h0000_0400);
    chk("tgt_bubble", Inst, NOP);
    cyc();
    #1;
    chk("tgt_addr1", bus.addr, 32'h0000_0400);
    sb.push_back('{inst: 32'hA5A5_0400, plus4: 32'h0000_0404});
    sb_pop();
    cyc();
    mem_lat = 0;

    // PC wrap at the top of the address space.
    Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
    #1;
    chk("wrap_flush", {31'd0, flush}, 32'd1);
    cyc();
    Redirect = 1'b0;
    #1;
    chk("wrap_addr", bus.addr, 32'hFFFF_FFFC);
    sb.push_back('{inst: 32'h5A5A_FFFC, plus4: 32'h0000_0000});
    sb_pop();
    cyc();
    #1;
    chk("wrap_next", bus.addr, 32'h0000_0000);
    sb.push_back('{inst: 32'hA5A5_0000, plus4: 32'h0000_0004});
    sb_pop();
    cyc();

    // Asynchronous reset in the middle of DROP.
    mem_hold = 1'b1;
    Redirect = 1'b1; RedirectPC = 32'h0000_0800;
    #1;
    chk("ar_addr", bus.addr, 32'h0000_0004);
    chk("ar_flush", {31'd0, flush}, 32'd1);
    cyc();
    #1;
    chk("ar_drop_req", {31'd0, bus.req}, 32'd1);
    chk("ar_drop_addr", bus.addr, 32'h0000_0004);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_req", {31'd0, bus.req}, 32'd0);
    chk("ar_inst", Inst, NOP);
    chk("ar_plus4", PC_Plus4, 32'h0000_0104);
    chk("ar_flush0", {31'd0, flush}, 32'd0);
    chk("ar_addr_rst", bus.addr, 32'h0000_0100);
    cyc();
    Redirect = 1'b0; mem_hold = 1'b0; reset = 1'b0;
    #1;
    chk("ar_first_req", {31'd0, bus.req}, 32'd1);
    chk("ar_first_addr", bus.addr, 32'h0000_0100);
    sb.push_back('{inst: 32'hA5A5_0100, plus4: 32'h0000_0104});
    sb_pop();
    cyc();

    if (sb.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_leftover got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
